// File: rtl/ble_bit_sampler.sv
// BLE symbol timing recovery: synchronizes the raw demodulated bit, tracks bit-edge phase with a
// first-order early/late loop and emits one majority-voted bit per symbol with a lock flag.
module ble_bit_sampler #(
  parameter int unsigned OSR         = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_EDGES  = 4,
  parameter int unsigned MAX_RUN     = 16
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic enable,
  input  logic sample_en,
  input  logic rx_in,
  output logic bit_out,
  output logic bit_valid,
  output logic locked
);

  localparam int unsigned PhW   = $clog2(OSR);
  localparam int unsigned GoodW = $clog2(LOCK_EDGES + 1);
  localparam int unsigned RunW  = $clog2(MAX_RUN + 1);

  localparam logic [PhW:0]     OsrV   = (PhW + 1)'(OSR);
  localparam logic [PhW-1:0]   PhLast = PhW'(OSR - 1);
  localparam logic [PhW-1:0]   PhHalf = PhW'(OSR / 2);
  localparam logic [PhW-1:0]   PhDec  = PhW'(OSR / 2 + 1);
  localparam logic [GoodW-1:0] LockV  = GoodW'(LOCK_EDGES);
  localparam logic [RunW-1:0]  RunV   = RunW'(MAX_RUN);

  localparam logic [0:0] StSearch = 1'b0;
  localparam logic [0:0] StTrack  = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             hist_q, hist_d;
  logic                   prev_q, prev_d;
  logic [0:0]             state_q, state_d;
  logic [PhW-1:0]         ph_q, ph_d;
  logic [GoodW-1:0]       good_q, good_d;
  logic [RunW-1:0]        run_q, run_d;
  logic                   locked_q, locked_d;
  logic                   bit_out_q, bit_out_d;
  logic                   valid_q, valid_d;

  logic           s;
  logic           edge_s;
  logic           maj;
  logic           good_edge;
  logic [PhW-1:0] ph_inc;
  logic [PhW:0]   ph_w;
  logic [PhW-1:0] ph_p2;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], rx_in};
  assign s         = sync_q[SYNC_STAGES-1];
  assign edge_s    = s ^ prev_q;
  // Vote over the two stored samples plus the one arriving on this strobe.
  assign maj       = (hist_q[1] & hist_q[0]) | (hist_q[1] & s) | (hist_q[0] & s);
  assign good_edge = (ph_q == PhLast) || (ph_q == '0) || (ph_q == PhW'(1));
  assign ph_inc    = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
  assign ph_w      = {1'b0, ph_q} + 2'd2;
  assign ph_p2     = (ph_w >= OsrV) ? PhW'(ph_w - OsrV) : ph_w[PhW-1:0];

  always_comb begin
    hist_d    = hist_q;
    prev_d    = prev_q;
    state_d   = state_q;
    ph_d      = ph_q;
    good_d    = good_q;
    run_d     = run_q;
    locked_d  = locked_q;
    bit_out_d = bit_out_q;
    valid_d   = 1'b0;

    if (sample_en) begin
      hist_d = {hist_q[0], s};
      prev_d = s;
      if (state_q == StSearch) begin
        if (edge_s) begin
          state_d  = StTrack;
          ph_d     = PhW'(1);
          good_d   = '0;
          run_d    = '0;
          locked_d = 1'b0;
        end
      end else begin
        if (!edge_s)                ph_d = ph_inc;
        else if (ph_q == '0)        ph_d = PhW'(1);
        else if (ph_q < PhHalf)     ph_d = ph_q;
        else                        ph_d = ph_p2;

        if (ph_q == PhDec) begin
          valid_d   = 1'b1;
          bit_out_d = maj;
        end

        if (edge_s) begin
          run_d = '0;
          if (!good_edge)            good_d = '0;
          else if (good_q != LockV)  good_d = good_q + 1'b1;
        end else if (ph_q == PhDec) begin
          run_d = run_q + 1'b1;
        end
        locked_d = (good_d == LockV);

        // Too long without a transition: the phase estimate is no longer trustworthy.
        if (run_d == RunV) begin
          state_d  = StSearch;
          ph_d     = '0;
          run_d    = '0;
          good_d   = '0;
          locked_d = 1'b0;
        end
      end
    end

    if (!enable) begin
      state_d  = StSearch;
      ph_d     = '0;
      good_d   = '0;
      run_d    = '0;
      locked_d = 1'b0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      hist_q    <= '0;
      prev_q    <= 1'b0;
      state_q   <= StSearch;
      ph_q      <= '0;
      good_q    <= '0;
      run_q     <= '0;
      locked_q  <= 1'b0;
      bit_out_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      ph_q      <= ph_d;
      good_q    <= good_d;
      run_q     <= run_d;
      locked_q  <= locked_d;
      bit_out_q <= bit_out_d;
      valid_q   <= valid_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = valid_q;
  assign locked    = locked_q;

endmodule
